// File: rtl/ad_preadder_pipe_pkg.sv
// Shared constants for the A/D pre-adder front end: INMODE bit positions,
// overflow handling modes and A source selection names.
package ad_preadder_pipe_pkg;

    localparam int INMODE_W      = 4;
    localparam int INMODE_A1_SEL = 0;
    localparam int INMODE_ZERO_A = 1;
    localparam int INMODE_ADD_D  = 2;
    localparam int INMODE_NEG_A  = 3;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    localparam string A_INPUT_DIRECT  = "Direct";
    localparam string A_INPUT_CASCADE = "Cascade";

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ad_preadder_pipe_if.sv
// Operand and result bundle between the slice input ports and the pre-adder.
// valid_in/valid_out form a tag only (no ready, no backpressure): valid_out is valid_in delayed by the pipeline latency.
interface ad_preadder_pipe_if import ad_preadder_pipe_pkg::*; #(
    parameter int A_W  = 30,
    parameter int D_W  = 25,
    parameter int AD_W = 25
) ();

    logic [A_W-1:0]      A;
    logic [A_W-1:0]      ACIN;
    logic [D_W-1:0]      D;
    logic [INMODE_W-1:0] INMODE;
    logic                valid_in;
    logic [A_W-1:0]      ACOUT;
    logic [A_W-1:0]      XMUX;
    logic [AD_W-1:0]     AMULT;
    logic                ovf;
    logic                valid_out;

    modport master (
        output A, ACIN, D, INMODE, valid_in,
        input  ACOUT, XMUX, AMULT, ovf, valid_out
    );

    modport slave (
        input  A, ACIN, D, INMODE, valid_in,
        output ACOUT, XMUX, AMULT, ovf, valid_out
    );

endinterface

// File: rtl/ad_preadder_pipe_reg_stage.sv
// One optional pipeline stage: clock-enabled register with async clear,
// or a plain wire when the stage is configured out.
module preadder_reg_stage #(
    parameter int W  = 1,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (EN) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (ce) begin
                q <= d;
            end
        end
    end else begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst ^ ce;
        assign q = d;
    end

endmodule

// File: rtl/ad_preadder_pipe.sv
// Parametrised A/D pre-adder: A/D/INMODE input registers, signed add/subtract
// with wrap or saturate, optional AD register and a latency-matched valid tag.
module ad_preadder_pipe import ad_preadder_pipe_pkg::*; #(
    parameter int    A_W       = 30,
    parameter int    D_W       = 25,
    parameter int    AD_W      = 25,
    parameter int    AREG      = 1,
    parameter int    ACASCREG  = 1,
    parameter string A_INPUT   = A_INPUT_DIRECT,
    parameter int    USE_DPORT = 1,
    parameter int    DREG      = 1,
    parameter int    INMODEREG = 1,
    parameter int    ADREG     = 1,
    parameter int    SAT_MODE  = SAT_WRAP
) (
    input logic clk,
    input logic RSTA,
    input logic RSTD,
    input logic RSTINMODE,
    input logic CEA1,
    input logic CEA2,
    input logic CED,
    input logic CEAD,
    input logic CEINMODE,
    ad_preadder_pipe_if.slave bus
);

    localparam bit A_CASC = (A_INPUT == A_INPUT_CASCADE);
    localparam bit AD_EN  = (ADREG == 1) && (USE_DPORT == 1);
    // Latency follows the AD stage that is actually present, not just ADREG.
    localparam int LAT    = max3(AREG, DREG, INMODEREG) + (AD_EN ? 1 : 0);

    logic [A_W-1:0]      a_src;
    logic [A_W-1:0]      a1_q;
    logic [A_W-1:0]      a2_q;
    logic [A_W-1:0]      a_sel;
    logic [D_W-1:0]      d_q;
    logic [INMODE_W-1:0] inmode_q;
    logic                zero_a;
    logic                add_d;
    logic                neg_a;
    logic signed [AD_W:0] a_op;
    logic signed [AD_W:0] d_op;
    logic signed [AD_W:0] sum;
    logic [AD_W-1:0]     ad_res;
    logic                ad_ovf;
    logic [AD_W:0]       ad_q;
    logic                unused_a_hi;

    assign a_src = A_CASC ? bus.ACIN : bus.A;

    // A single-register A path occupies the A2 slot, so XMUX is always a2_q.
    preadder_reg_stage #(.W(A_W), .EN(AREG == 2)) u_a1 (
        .clk(clk), .rst(RSTA), .ce(CEA1), .d(a_src), .q(a1_q)
    );

    preadder_reg_stage #(.W(A_W), .EN(AREG >= 1)) u_a2 (
        .clk(clk), .rst(RSTA), .ce(CEA2), .d(a1_q), .q(a2_q)
    );

    preadder_reg_stage #(.W(D_W), .EN(DREG == 1)) u_d (
        .clk(clk), .rst(RSTD), .ce(CED), .d(bus.D), .q(d_q)
    );

    preadder_reg_stage #(.W(INMODE_W), .EN(INMODEREG == 1)) u_inmode (
        .clk(clk), .rst(RSTINMODE), .ce(CEINMODE), .d(bus.INMODE), .q(inmode_q)
    );

    assign bus.XMUX  = a2_q;
    assign bus.ACOUT = (AREG == 2 && ACASCREG == 1) ? a1_q : a2_q;
    assign a_sel     = (AREG == 2 && inmode_q[INMODE_A1_SEL]) ? a1_q : a2_q;
    assign unused_a_hi = ^a_sel;

    assign zero_a = inmode_q[INMODE_ZERO_A];
    assign add_d  = (USE_DPORT == 1) && inmode_q[INMODE_ADD_D];
    assign neg_a  = (USE_DPORT == 1) && inmode_q[INMODE_NEG_A];

    // One guard bit is enough: |d_op - a_op| never exceeds 2^AD_W - 1.
    always_comb begin
        a_op   = zero_a ? '0 : {a_sel[AD_W-1], a_sel[AD_W-1:0]};
        d_op   = add_d ? {{(AD_W+1-D_W){d_q[D_W-1]}}, d_q} : '0;
        sum    = neg_a ? (d_op - a_op) : (d_op + a_op);
        ad_ovf = sum[AD_W] ^ sum[AD_W-1];
        ad_res = sum[AD_W-1:0];
        if (SAT_MODE == SAT_CLAMP && ad_ovf) begin
            ad_res = sum[AD_W] ? {1'b1, {(AD_W-1){1'b0}}} : {1'b0, {(AD_W-1){1'b1}}};
        end
    end

    preadder_reg_stage #(.W(AD_W + 1), .EN(AD_EN)) u_ad (
        .clk(clk), .rst(RSTD), .ce(CEAD), .d({ad_ovf, ad_res}), .q(ad_q)
    );

    assign bus.AMULT = ad_q[AD_W-1:0];
    assign bus.ovf   = ad_q[AD_W];

    // The valid tag shifts every cycle regardless of the data clock enables.
    logic vld [LAT+1];
    assign vld[0] = bus.valid_in;

    for (genvar i = 0; i < LAT; i++) begin : g_vld
        preadder_reg_stage #(.W(1), .EN(1'b1)) u_v (
            .clk(clk), .rst(RSTA), .ce(1'b1), .d(vld[i]), .q(vld[i+1])
        );
    end

    assign bus.valid_out = vld[LAT];

endmodule
